// File: rtl/m_uart_rx_pkg.sv
// -----------------------------------------------------------------------------
// m_uart_rx_pkg
//   Shared definitions for the UART receive path.
//   - UART_CNT_DEF : default clocks per bit (100 MHz / 100 = 1 Mbaud). The
//                    transmitter uses the same constant, so RX and TX baud
//                    rates cannot drift apart.
//   - rx_state_e   : receiver FSM state encoding (3 bits).
//   - cnt_width()  : width of a counter that must hold the value UART_CNT.
// -----------------------------------------------------------------------------
package m_uart_rx_pkg;

    localparam int unsigned UART_CNT_DEF = 100;
    localparam int unsigned DATA_BITS    = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_e;

    // Bits needed to represent 1..clks (the counter never holds 0 in use,
    // but clks itself must fit).
    function automatic int unsigned cnt_width(input int unsigned clks);
        return $clog2(clks + 1);
    endfunction

endpackage

// File: rtl/m_uart_rx_sync2.sv
// -----------------------------------------------------------------------------
// m_sync2
//   Two-flop synchronizer for a single asynchronous input.
//   The reset value is a parameter; for a UART line it is 1 (idle high), so
//   leaving reset never looks like a start-bit falling edge.
// Ports
//   w_clk   in  1  sampling clock
//   w_rst_n in  1  synchronous active-low reset
//   w_d     in  1  asynchronous input
//   w_q     out 1  synchronized output (two clocks of latency)
// -----------------------------------------------------------------------------
module m_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic w_clk,
    input  logic w_rst_n,
    input  logic w_d,
    output logic w_q
);

    logic meta_q;
    logic sync_q;

    // NOTE: clocked state is always written with non-blocking assignments so
    // every flop samples the value from before the edge; with blocking
    // assignments sync_q would collapse onto meta_q and the second stage
    // would disappear.
    always_ff @(posedge w_clk) begin
        if (!w_rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= w_d;
            sync_q <= meta_q;
        end
    end

    assign w_q = sync_q;

endmodule

// File: rtl/m_uart_rx.sv
// -----------------------------------------------------------------------------
// m_uart_rx
//   UART receiver, 8N1, LSB first, fixed baud = clock / UART_CNT.
//   Sits between the board pin (PC -> FPGA) and the main logic and mirrors
//   the on-chip transmitter, so an RX -> TX loopback echoes at the same baud.
//   Each good frame produces a one-cycle w_valid pulse with the byte on
//   w_dout; a frame whose stop bit samples low produces a one-cycle w_ferr
//   pulse and leaves w_dout untouched.
// Parameters
//   UART_CNT  clocks per bit, must be >= 8. Mid-bit point is UART_CNT/2.
// Ports
//   w_clk      in   1  system clock, the only clock
//   w_rst_n    in   1  synchronous active-low reset
//   w_uart_rx  in   1  asynchronous serial line, idle high
//   w_valid    out  1  one-cycle pulse: w_dout holds a newly received byte
//   w_dout     out  8  last good byte, held until the next good frame
//   w_ferr     out  1  one-cycle pulse: stop bit sampled low
//   w_busy     out  1  high in every state except IDLE
// -----------------------------------------------------------------------------
module m_uart_rx
    import m_uart_rx_pkg::*;
#(
    parameter int unsigned UART_CNT = UART_CNT_DEF
) (
    input  logic                 w_clk,
    input  logic                 w_rst_n,
    input  logic                 w_uart_rx,
    output logic                 w_valid,
    output logic [DATA_BITS-1:0] w_dout,
    output logic                 w_ferr,
    output logic                 w_busy
);

    localparam int unsigned       CNT_W   = cnt_width(UART_CNT);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MID = CNT_W'(UART_CNT / 2);
    localparam logic [CNT_W-1:0]  CNT_END = CNT_W'(UART_CNT);
    localparam logic [2:0]        IDX_LAST = 3'(DATA_BITS - 1);

    // -------------------------------------------------------------------------
    // Input synchronizer: every decision below looks at rx_sync only.
    // -------------------------------------------------------------------------
    logic rx_sync;

    m_sync2 #(
        .RST_VAL (1'b1)
    ) u_sync (
        .w_clk   (w_clk),
        .w_rst_n (w_rst_n),
        .w_d     (w_uart_rx),
        .w_q     (rx_sync)
    );

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    rx_state_e              state_q, state_d;
    logic [CNT_W-1:0]       cnt_q,   cnt_d;
    logic [2:0]             idx_q,   idx_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [DATA_BITS-1:0]   dout_q,  dout_d;
    logic                   valid_q, valid_d;
    logic                   ferr_q,  ferr_d;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every signal driven here gets a default before the case statement;
    // any path that left one unassigned would infer a latch.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        dout_d  = dout_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (!rx_sync) begin
                    state_d = ST_START;
                end
            end

            // Re-check the line half a bit after the edge; a line that is
            // high again was a glitch and is dropped silently.
            ST_START: begin
                if (cnt_q == CNT_MID) begin
                    if (rx_sync) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DATA;
                        idx_d   = '0;
                    end
                end
            end

            // From here on samples are one full bit apart, so each lands at
            // mid-bit. LSB arrives first: shift right, new bit in at the top.
            ST_DATA: begin
                if (cnt_q == CNT_END) begin
                    shift_d = {rx_sync, shift_q[DATA_BITS-1:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_STOP;
                    end
                end
            end

            // Leaving at mid-stop-bit gives half a bit of slack to catch the
            // start edge of a back-to-back frame.
            ST_STOP: begin
                if (cnt_q == CNT_END) begin
                    if (rx_sync) begin
                        dout_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = ST_BREAK;
                    end
                end
            end

            // A low line after a bad stop bit is a break, not a new start;
            // wait for it to return high before arming again.
            ST_BREAK: begin
                if (rx_sync) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Bit-timing counter runs 1..UART_CNT and restarts on every state
        // change, so each state measures time from its own entry.
        if ((state_d != state_q) || (cnt_q == CNT_END)) begin
            cnt_d = CNT_ONE;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // -------------------------------------------------------------------------
    // Control and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge w_clk) begin
        if (!w_rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= CNT_ONE;
            idx_q   <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    // NOTE: the shift register is pure datapath and is fully overwritten by
    // eight samples before it is ever copied to w_dout, so it has no reset;
    // keeping it out of the reset block stops reset acting as a load enable.
    always_ff @(posedge w_clk) begin
        shift_q <= shift_d;
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign w_valid = valid_q;
    assign w_ferr  = ferr_q;
    assign w_dout  = dout_q;
    assign w_busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_m_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_m_uart_rx
//   Self-checking bench for m_uart_rx. A behavioural serial transmitter drives
//   the line one bit time per bit; every frame it sends is recorded in a
//   reference model (queue of expected bytes, count of expected framing
//   errors). A negedge monitor checks every pulse against the model.
// -----------------------------------------------------------------------------
module tb_m_uart_rx;

    localparam int unsigned UART_CNT = 100;
    localparam int unsigned HALF     = UART_CNT / 2;
    // Start edge on the pin -> valid pulse: 9.5 bit times + 3 cycles
    // (two synchronizer flops plus the registered IDLE detection).
    localparam int unsigned LATENCY  = 9 * UART_CNT + HALF + 3;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx    = 1'b1;
    logic       valid;
    logic       ferr;
    logic       busy;
    logic [7:0] dout;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    // Reference model state
    logic [7:0] exp_q[$];
    int         exp_ferr_pend = 0;
    int         exp_nvalid    = 0;
    int         exp_nferr     = 0;
    logic [7:0] last_good     = 8'h00;

    // Observed pulse counts
    int n_valid = 0;
    int n_ferr  = 0;

    // Latency probe
    bit lat_arm   = 1'b0;
    int lat_start = 0;

    bit         prev_valid = 1'b0;
    bit         prev_ferr  = 1'b0;
    logic [7:0] mon_exp;

    m_uart_rx #(
        .UART_CNT (UART_CNT)
    ) dut (
        .w_clk     (clk),
        .w_rst_n   (rst_n),
        .w_uart_rx (rx),
        .w_valid   (valid),
        .w_dout    (dout),
        .w_ferr    (ferr),
        .w_busy    (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // All stimulus changes happen 1 time unit after a rising edge.
    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Behavioural transmitter: start bit, 8 data bits LSB first, stop bit.
    // A low stop bit leaves the line low on return (the caller ends the break).
    task automatic send_frame(input logic [7:0] data, input logic stop_bit, input bit arm_lat);
        if (stop_bit) begin
            exp_q.push_back(data);
            exp_nvalid++;
        end else begin
            exp_ferr_pend++;
            exp_nferr++;
        end
        rx = 1'b0;
        if (arm_lat) begin
            lat_start = cyc;
            lat_arm   = 1'b1;
        end
        wait_cyc(UART_CNT);
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            wait_cyc(UART_CNT);
        end
        rx = stop_bit;
        wait_cyc(UART_CNT);
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_nvalid"}, n_valid, exp_nvalid);
        check({tag, "_nferr"},  n_ferr,  exp_nferr);
    endtask

    // Pulse monitor
    always @(negedge clk) begin
        if (valid && ferr) begin
            check("valid_ferr_exclusive", {31'b0, valid & ferr}, 32'd0);
        end
        if (valid) begin
            n_valid++;
            check("valid_width", {31'b0, prev_valid}, 32'd0);
            if (exp_q.size() == 0) begin
                check("valid_unexpected", {31'b0, valid}, 32'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                check("dout", {24'b0, dout}, {24'b0, mon_exp});
                last_good = mon_exp;
            end
            if (lat_arm) begin
                check("latency", cyc - lat_start, LATENCY);
                lat_arm = 1'b0;
            end
        end
        if (ferr) begin
            n_ferr++;
            check("ferr_width", {31'b0, prev_ferr}, 32'd0);
            if (exp_ferr_pend == 0) begin
                check("ferr_unexpected", {31'b0, ferr}, 32'd0);
            end else begin
                exp_ferr_pend--;
            end
            check("ferr_dout_hold", {24'b0, dout}, {24'b0, last_good});
        end
        prev_valid = valid;
        prev_ferr  = ferr;
    end

    // Watchdog: every wait below is a fixed cycle count, this only guards
    // against a stuck simulation.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rnd_data;
        bit         rnd_good;

        // Reset values
        rst_n = 1'b0;
        rx    = 1'b1;
        wait_cyc(3);
        check("rst_valid", {31'b0, valid}, 32'd0);
        check("rst_ferr",  {31'b0, ferr},  32'd0);
        check("rst_dout",  {24'b0, dout},  32'd0);
        check("rst_busy",  {31'b0, busy},  32'd0);
        rst_n = 1'b1;
        wait_cyc(10);

        // 1. Single good frame, with latency probe
        send_frame(8'h61, 1'b1, 1'b1);
        wait_cyc(20);
        check_counts("t1");
        check("t1_dout", {24'b0, dout}, 32'h61);
        check("t1_busy", {31'b0, busy}, 32'd0);

        // 2. Short glitch is rejected
        rx = 1'b0;
        wait_cyc(20);
        check("t2_busy_in_glitch", {31'b0, busy}, 32'd1);
        rx = 1'b1;
        wait_cyc(200);
        check("t2_busy_after", {31'b0, busy}, 32'd0);
        check_counts("t2");

        // 3. Bad stop bit, line held low, then recovery
        send_frame(8'hA5, 1'b0, 1'b0);
        wait_cyc(300);
        check("t3_busy_break", {31'b0, busy}, 32'd1);
        check("t3_dout_held",  {24'b0, dout}, 32'h61);
        check_counts("t3a");
        rx = 1'b1;
        wait_cyc(10);
        check("t3_busy_idle", {31'b0, busy}, 32'd0);
        send_frame(8'h3C, 1'b1, 1'b0);
        wait_cyc(20);
        check("t3_dout", {24'b0, dout}, 32'h3C);
        check_counts("t3b");

        // 4. Back-to-back frames, no idle gap
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        send_frame(8'h55, 1'b1, 1'b0);
        wait_cyc(20);
        check("t4_dout", {24'b0, dout}, 32'h55);
        check_counts("t4");

        // 5. Reset mid-DATA discards the frame
        rx = 1'b0;                       // start bit
        wait_cyc(UART_CNT);
        rx = 1'b0; wait_cyc(UART_CNT);   // bit 0
        rx = 1'b1; wait_cyc(UART_CNT);   // bit 1
        rx = 1'b1; wait_cyc(UART_CNT);   // bit 2
        check("t5_busy_pre", {31'b0, busy}, 32'd1);
        rst_n = 1'b0;
        rx    = 1'b1;
        wait_cyc(1);
        check("t5_rst_valid", {31'b0, valid}, 32'd0);
        check("t5_rst_ferr",  {31'b0, ferr},  32'd0);
        check("t5_rst_dout",  {24'b0, dout},  32'd0);
        check("t5_rst_busy",  {31'b0, busy},  32'd0);
        last_good = 8'h00;
        rst_n = 1'b1;
        wait_cyc(12 * UART_CNT);
        check_counts("t5a");
        send_frame(8'h7E, 1'b1, 1'b0);
        wait_cyc(20);
        check("t5_dout", {24'b0, dout}, 32'h7E);
        check_counts("t5b");

        // 6. Loopback-style: transmitter model sends 0x61
        send_frame(8'h61, 1'b1, 1'b0);
        wait_cyc(20);
        check("t6_dout", {24'b0, dout}, 32'h61);

        // Randomized frames: random data, ~10% bad stop bits, random gaps
        for (int f = 0; f < 30; f++) begin
            rnd_data = 8'($urandom_range(0, 255));
            rnd_good = ($urandom_range(0, 9) != 0);
            send_frame(rnd_data, rnd_good, 1'b0);
            if (!rnd_good) begin
                rx = 1'b1;
                wait_cyc($urandom_range(5, 60));
            end else begin
                wait_cyc($urandom_range(0, 60));
            end
        end
        wait_cyc(20);
        check_counts("rand");
        check("rand_queue_empty", exp_q.size(), 32'd0);
        check("rand_ferr_pending", exp_ferr_pend, 32'd0);
        check("rand_busy", {31'b0, busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
